// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, control-bundle layout, ALU op codes,
// decode/issue FSM states and immediate-format classification.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int CTRL_W = 8;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Bit positions inside {regwrite,memread,memwrite,branch,jump,alusrc,aluop[1:0]}
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_BRANCH   = 4;
    localparam int CTRL_JUMP     = 3;
    localparam int CTRL_ALUSRC   = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_READ  = 2'd2,
        ST_ISSUE = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_t;

    function automatic logic is_supported(input logic [6:0] opcode);
        case (opcode)
            OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic imm_fmt_t imm_format(input logic [6:0] opcode);
        case (opcode)
            OP_IALU, OP_LOAD, OP_JALR: return FMT_I;
            OP_STORE:                  return FMT_S;
            OP_BRANCH:                 return FMT_B;
            OP_LUI, OP_AUIPC:          return FMT_U;
            OP_JAL:                    return FMT_J;
            default:                   return FMT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/gerador_imediato.sv
// Combinational immediate generator: extracts and sign-extends the immediate
// of an RV32I instruction word according to its format.
module gerador_imediato
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] imm
);

    imm_fmt_t fmt;

    always_comb begin
        fmt = imm_format(instr[6:0]);
        imm = '0;
        case (fmt)
            FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm = {instr[31:12], 12'h000};
            FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/estagio_decodificacao.sv
// Decode/issue stage in front of a registered-read register file. Latches one
// instruction, waits for its sources/destination to be free, then issues it.
module estagio_decodificacao
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [XLEN-1:0]   instr,
    output logic              instr_ready,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [4:0]        rd,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [XLEN-1:0]   issue_imm,
    output logic [CTRL_W-1:0] issue_ctrl,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rd,
    output logic              illegal
);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic              illegal_q, illegal_d;

    logic [4:0]        f_rs1, f_rs2, f_rd;
    logic [CTRL_W-1:0] ctrl;
    logic              uses_rs1, uses_rs2;
    logic              hazard;
    logic              issue_fire;
    logic              active;
    logic [XLEN-1:0]   imm_raw;

    assign f_rs1 = instr_q[19:15];
    assign f_rs2 = instr_q[24:20];
    assign f_rd  = instr_q[11:7];

    gerador_imediato u_gerador_imediato (
        .instr (instr_q),
        .imm   (imm_raw)
    );

    always_comb begin
        ctrl     = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (instr_q[6:0])
            OP_R: begin
                ctrl[CTRL_REGWRITE]               = 1'b1;
                ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALUOP_RTYPE;
                uses_rs1                          = 1'b1;
                uses_rs2                          = 1'b1;
            end
            OP_IALU: begin
                ctrl[CTRL_REGWRITE]               = 1'b1;
                ctrl[CTRL_ALUSRC]                 = 1'b1;
                ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALUOP_ITYPE;
                uses_rs1                          = 1'b1;
            end
            OP_LOAD: begin
                ctrl[CTRL_REGWRITE]               = 1'b1;
                ctrl[CTRL_MEMREAD]                = 1'b1;
                ctrl[CTRL_ALUSRC]                 = 1'b1;
                ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALUOP_ADD;
                uses_rs1                          = 1'b1;
            end
            OP_STORE: begin
                ctrl[CTRL_MEMWRITE]               = 1'b1;
                ctrl[CTRL_ALUSRC]                 = 1'b1;
                ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALUOP_ADD;
                uses_rs1                          = 1'b1;
                uses_rs2                          = 1'b1;
            end
            OP_BRANCH: begin
                ctrl[CTRL_BRANCH]                 = 1'b1;
                ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALUOP_BRANCH;
                uses_rs1                          = 1'b1;
                uses_rs2                          = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                ctrl[CTRL_REGWRITE]               = 1'b1;
                ctrl[CTRL_ALUSRC]                 = 1'b1;
            end
            OP_JAL: begin
                ctrl[CTRL_REGWRITE]               = 1'b1;
                ctrl[CTRL_JUMP]                   = 1'b1;
            end
            OP_JALR: begin
                ctrl[CTRL_REGWRITE]               = 1'b1;
                ctrl[CTRL_JUMP]                   = 1'b1;
                ctrl[CTRL_ALUSRC]                 = 1'b1;
                uses_rs1                          = 1'b1;
            end
            default: begin
                ctrl     = '0;
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
        endcase
    end

    // Registered busy bits only: a writeback clearing a bit is seen one cycle later,
    // which guarantees the register-file write has landed before the read.
    assign hazard = (uses_rs1 & busy_q[f_rs1])
                  | (uses_rs2 & busy_q[f_rs2])
                  | (ctrl[CTRL_REGWRITE] & busy_q[f_rd]);

    assign issue_fire = (state_q == ST_ISSUE) && issue_ready;

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        illegal_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    if (is_supported(instr[6:0])) begin
                        state_d = ST_CHECK;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (!hazard) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (issue_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Set is applied after clear so an issue and writeback to the same register keep it busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid && (wb_rd != 5'd0)) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (issue_fire && ctrl[CTRL_REGWRITE] && (f_rd != 5'd0)) begin
            busy_d[f_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            busy_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            busy_q    <= busy_d;
            illegal_q <= illegal_d;
        end
    end

    assign active      = (state_q != ST_IDLE);
    assign instr_ready = (state_q == ST_IDLE);
    assign issue_valid = (state_q == ST_ISSUE);
    assign rs1         = active ? f_rs1 : 5'd0;
    assign rs2         = active ? f_rs2 : 5'd0;
    assign rd          = active ? f_rd  : 5'd0;
    assign issue_imm   = active ? imm_raw : '0;
    assign issue_ctrl  = active ? ctrl : '0;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_estagio_decodificacao.sv
// Self-checking bench for estagio_decodificacao: directed vectors, hand-written
// hazard/reset sequences, and randomized instructions against an assembler-style model.
module tb_estagio_decodificacao;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_ready;
    logic [4:0]  rs1, rs2, rd;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [31:0] issue_imm;
    logic [7:0]  issue_ctrl;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        illegal;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model_busy = '0;

    always #5 clk = ~clk;

    estagio_decodificacao dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_imm   (issue_imm),
        .issue_ctrl  (issue_ctrl),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .illegal     (illegal)
    );

    // Instruction classes: 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, 9 unsupported
    localparam logic [7:0] CTRL_TBL [9] = '{8'h82, 8'h87, 8'hC4, 8'h24, 8'h11, 8'h84, 8'h84, 8'h88, 8'h8C};
    localparam bit USES1_TBL [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam bit USES2_TBL [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    typedef struct {
        logic [31:0] instr;
        logic        exp_illegal;
        logic [31:0] exp_imm;
        logic [7:0]  exp_ctrl;
        logic [4:0]  exp_rd;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] word);
        checkOutput("ready_before_accept", {31'd0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        instr       = word;
        tick();
        instr_valid = 1'b0;
        instr       = '0;
    endtask

    task automatic waitIssue(input int max_cycles, output int cycles);
        cycles = 0;
        while (!issue_valid && cycles < max_cycles) begin
            tick();
            cycles++;
        end
    endtask

    task automatic wbClear(input logic [4:0] r);
        wb_valid = 1'b1;
        wb_rd    = r;
        tick();
        wb_valid = 1'b0;
        wb_rd    = '0;
        if (r != 5'd0) model_busy[r] = 1'b0;
    endtask

    // Assembler direction: build an instruction word from its fields and immediate value.
    function automatic logic [31:0] encode(input int cls, input logic [4:0] r_rd, input logic [4:0] r_rs1,
                                           input logic [4:0] r_rs2, input logic [31:0] imm, input logic [2:0] f3);
        logic [31:0] w;
        case (cls)
            0: w = {7'b0000000, r_rs2, r_rs1, f3, r_rd, 7'b0110011};
            1: w = {imm[11:0], r_rs1, f3, r_rd, 7'b0010011};
            2: w = {imm[11:0], r_rs1, f3, r_rd, 7'b0000011};
            3: w = {imm[11:5], r_rs2, r_rs1, f3, imm[4:0], 7'b0100011};
            4: w = {imm[12], imm[10:5], r_rs2, r_rs1, f3, imm[4:1], imm[11], 7'b1100011};
            5: w = {imm[31:12], r_rd, 7'b0110111};
            6: w = {imm[31:12], r_rd, 7'b0010111};
            7: w = {imm[20], imm[10:1], imm[11], imm[19:12], r_rd, 7'b1101111};
            8: w = {imm[11:0], r_rs1, 3'b000, r_rd, 7'b1100111};
            default: w = {imm[24:0], 7'b1111111};
        endcase
        return w;
    endfunction

    task automatic runRandom();
        int          cls;
        int          v;
        int          cycles;
        int          hold;
        logic [4:0]  r_rd, r_rs1, r_rs2;
        logic [31:0] imm, word;
        logic [2:0]  f3;
        logic [19:0] upper;
        bit          hz, writes;

        cls   = $urandom_range(0, 9);
        r_rd  = 5'($urandom_range(0, 31));
        r_rs1 = 5'($urandom_range(0, 31));
        r_rs2 = 5'($urandom_range(0, 31));
        f3    = 3'($urandom_range(0, 7));
        upper = 20'($urandom());
        imm   = '0;
        case (cls)
            1, 2, 3, 8: begin v = int'($urandom_range(0, 4095)) - 2048; imm = v; end
            4:          begin v = (int'($urandom_range(0, 4095)) - 2048) * 2; imm = v; end
            5, 6:       imm = {upper, 12'h000};
            7:          begin v = (int'($urandom_range(0, 1048575)) - 524288) * 2; imm = v; end
            9:          imm = $urandom();
            default:    imm = '0;
        endcase
        word = encode(cls, r_rd, r_rs1, r_rs2, imm, f3);

        if (cls == 9) begin
            applyStimulus(word);
            checkOutput("rnd_illegal_pulse", {31'd0, illegal}, 32'd1);
            checkOutput("rnd_illegal_no_issue", {31'd0, issue_valid}, 32'd0);
            tick();
            checkOutput("rnd_illegal_drop", {31'd0, illegal}, 32'd0);
            return;
        end

        writes = CTRL_TBL[cls][7];
        hz = (USES1_TBL[cls] && model_busy[r_rs1]) || (USES2_TBL[cls] && model_busy[r_rs2])
           || (writes && model_busy[r_rd]);
        hold = $urandom_range(0, 2);
        issue_ready = (hold == 0);

        applyStimulus(word);
        if (hz) begin
            for (int k = 0; k < 4; k++) begin
                checkOutput("rnd_stall", {31'd0, issue_valid}, 32'd0);
                tick();
            end
            if (USES1_TBL[cls] && model_busy[r_rs1]) wbClear(r_rs1);
            if (USES2_TBL[cls] && model_busy[r_rs2]) wbClear(r_rs2);
            if (writes && model_busy[r_rd]) wbClear(r_rd);
        end
        waitIssue(20, cycles);
        checkOutput("rnd_latency", cycles, 32'd2);
        checkOutput("rnd_imm", issue_imm, imm);
        checkOutput("rnd_ctrl", {24'd0, issue_ctrl}, {24'd0, CTRL_TBL[cls]});
        if (writes) checkOutput("rnd_rd", {27'd0, rd}, {27'd0, r_rd});
        if (USES1_TBL[cls]) checkOutput("rnd_rs1", {27'd0, rs1}, {27'd0, r_rs1});
        if (USES2_TBL[cls]) checkOutput("rnd_rs2", {27'd0, rs2}, {27'd0, r_rs2});
        for (int k = 0; k < hold; k++) begin
            tick();
            checkOutput("rnd_hold_valid", {31'd0, issue_valid}, 32'd1);
            checkOutput("rnd_hold_imm", issue_imm, imm);
        end
        issue_ready = 1'b1;
        tick();
        if (writes && r_rd != 5'd0) model_busy[r_rd] = 1'b1;
        checkOutput("rnd_busy", dut.busy_q, model_busy);
        if ($urandom_range(0, 1) == 1) begin
            wbClear(5'($urandom_range(0, 31)));
            checkOutput("rnd_busy_after_wb", dut.busy_q, model_busy);
        end
    endtask

    initial begin
        int cycles;

        vecs[0] = '{32'h00700293, 1'b0, 32'h00000007, 8'h87, 5'd5};
        vecs[1] = '{32'hFE208CE3, 1'b0, 32'hFFFFFFF8, 8'h11, 5'd25};
        vecs[2] = '{32'h123450B7, 1'b0, 32'h12345000, 8'h84, 5'd1};
        vecs[3] = '{32'h00528333, 1'b0, 32'h00000000, 8'h82, 5'd6};
        vecs[4] = '{32'h0020A423, 1'b0, 32'h00000008, 8'h24, 5'd8};
        vecs[5] = '{32'hFFC12183, 1'b0, 32'hFFFFFFFC, 8'hC4, 5'd3};
        vecs[6] = '{32'h001000EF, 1'b0, 32'h00000800, 8'h88, 5'd1};
        vecs[7] = '{32'h000280E7, 1'b0, 32'h00000000, 8'h8C, 5'd1};
        vecs[8] = '{32'hFFFFF217, 1'b0, 32'hFFFFF000, 8'h84, 5'd4};
        vecs[9] = '{32'h00000073, 1'b1, 32'h00000000, 8'h00, 5'd0};

        tick();
        tick();
        checkOutput("reset_instr_ready", {31'd0, instr_ready}, 32'd1);
        checkOutput("reset_issue_valid", {31'd0, issue_valid}, 32'd0);
        checkOutput("reset_illegal", {31'd0, illegal}, 32'd0);
        checkOutput("reset_rs_rd", {17'd0, rs1, rs2, rd}, 32'd0);
        checkOutput("reset_ctrl_imm", issue_imm | {24'd0, issue_ctrl}, 32'd0);
        checkOutput("reset_busy", dut.busy_q, 32'd0);
        rst_n = 1'b1;
        tick();

        // addi x5,x0,7: three-cycle latency, busy[5] set on issue
        issue_ready = 1'b1;
        applyStimulus(32'h00700293);
        checkOutput("t1_cycle1", {31'd0, issue_valid}, 32'd0);
        tick();
        checkOutput("t1_cycle2", {31'd0, issue_valid}, 32'd0);
        tick();
        checkOutput("t1_cycle3", {31'd0, issue_valid}, 32'd1);
        checkOutput("t1_imm", issue_imm, 32'd7);
        checkOutput("t1_rd", {27'd0, rd}, 32'd5);
        checkOutput("t1_ctrl", {24'd0, issue_ctrl}, 32'h87);
        tick();
        checkOutput("t1_busy5", {31'd0, dut.busy_q[5]}, 32'd1);
        checkOutput("t1_idle_regs", {17'd0, rs1, rs2, rd}, 32'd0);

        // add x6,x5,x5 waits in CHECK until x5 is written back
        applyStimulus(32'h00528333);
        for (int k = 0; k < 5; k++) begin
            checkOutput("t2_stall_valid", {31'd0, issue_valid}, 32'd0);
            checkOutput("t2_stall_ready", {31'd0, instr_ready}, 32'd0);
            tick();
        end
        wbClear(5'd5);
        checkOutput("t2_wb_plus1", {31'd0, issue_valid}, 32'd0);
        tick();
        checkOutput("t2_wb_plus2", {31'd0, issue_valid}, 32'd0);
        tick();
        checkOutput("t2_wb_plus3", {31'd0, issue_valid}, 32'd1);
        checkOutput("t2_rs1", {27'd0, rs1}, 32'd5);
        checkOutput("t2_rs2", {27'd0, rs2}, 32'd5);
        tick();
        checkOutput("t2_busy", dut.busy_q, 32'h00000040);
        wbClear(5'd6);

        // beq sets no busy bit
        applyStimulus(32'hFE208CE3);
        waitIssue(20, cycles);
        checkOutput("t3_latency", cycles, 32'd2);
        checkOutput("t3_imm", issue_imm, 32'hFFFFFFF8);
        checkOutput("t3_ctrl", {24'd0, issue_ctrl}, 32'h11);
        tick();
        checkOutput("t3_busy", dut.busy_q, 32'd0);

        // unsupported opcode
        applyStimulus(32'h0000007F);
        checkOutput("t4_illegal", {31'd0, illegal}, 32'd1);
        checkOutput("t4_ready", {31'd0, instr_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("t4_no_issue", {31'd0, issue_valid}, 32'd0);
            tick();
            checkOutput("t4_pulse_end", {31'd0, illegal}, 32'd0);
        end

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].instr);
            if (vecs[i].exp_illegal) begin
                checkOutput("tbl_illegal", {31'd0, illegal}, 32'd1);
                checkOutput("tbl_illegal_no_issue", {31'd0, issue_valid}, 32'd0);
                tick();
                checkOutput("tbl_illegal_drop", {31'd0, illegal}, 32'd0);
            end else begin
                waitIssue(20, cycles);
                checkOutput("tbl_latency", cycles, 32'd2);
                checkOutput("tbl_imm", issue_imm, vecs[i].exp_imm);
                checkOutput("tbl_ctrl", {24'd0, issue_ctrl}, {24'd0, vecs[i].exp_ctrl});
                checkOutput("tbl_rd", {27'd0, rd}, {27'd0, vecs[i].exp_rd});
                tick();
                checkOutput("tbl_busy_bit", {31'd0, dut.busy_q[vecs[i].exp_rd]},
                            {31'd0, vecs[i].exp_ctrl[7] && (vecs[i].exp_rd != 5'd0)});
                if (vecs[i].exp_ctrl[7]) wbClear(vecs[i].exp_rd);
            end
        end

        // issue to x9 and writeback of x9 on the same edge: set wins
        issue_ready = 1'b0;
        applyStimulus(32'h00300493);
        waitIssue(20, cycles);
        checkOutput("t5_latency", cycles, 32'd2);
        issue_ready = 1'b1;
        wb_valid    = 1'b1;
        wb_rd       = 5'd9;
        tick();
        wb_valid    = 1'b0;
        checkOutput("t5_busy9", {31'd0, dut.busy_q[9]}, 32'd1);
        applyStimulus(32'h00100013);
        waitIssue(20, cycles);
        tick();
        checkOutput("t5_busy0", {31'd0, dut.busy_q[0]}, 32'd0);

        // reset while holding an issue: everything is discarded immediately
        issue_ready = 1'b0;
        applyStimulus(32'h00100393);
        waitIssue(20, cycles);
        checkOutput("t6_latency", cycles, 32'd2);
        instr_valid = 1'b1;
        instr       = 32'h00700293;
        tick();
        instr_valid = 1'b0;
        checkOutput("t6_no_accept_in_issue", {31'd0, instr_ready}, 32'd0);
        checkOutput("t6_rd_held", {27'd0, rd}, 32'd7);
        checkOutput("t6_busy_before", dut.busy_q, 32'h00000200);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_issue_valid", {31'd0, issue_valid}, 32'd0);
        checkOutput("t6_instr_ready", {31'd0, instr_ready}, 32'd1);
        checkOutput("t6_busy", dut.busy_q, 32'd0);
        checkOutput("t6_rd", {27'd0, rd}, 32'd0);
        tick();
        rst_n = 1'b1;
        model_busy = '0;
        tick();
        checkOutput("t6_after_release", {31'd0, issue_valid}, 32'd0);

        for (int n = 0; n < 80; n++) begin
            runRandom();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
